cache_wb_buffer: RTL and testbench



---
 rtl/cache_wb_buffer_if.sv | 38 +++
 rtl/cache_wb_buffer.sv | 184 ++++++++++++++++++
 tb/tb_cache_wb_buffer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_wb_buffer_if.sv
// ============================================================================
// Module      : cache_wb_buffer_if
// Description : AXI write address/data/response channels for the write-back buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cache_wb_buffer_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic [31:0]             awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    input  awready, wready, bvalid
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    output awready, wready, bvalid
  );
endinterface

`default_nettype wire

// File: rtl/cache_wb_buffer.sv
// ============================================================================
// Module      : cache_wb_buffer
// Description : FIFO of evicted dirty lines drained as AXI INCR bursts, with a
//               zero-latency lookup port. WB_MERGE_EN enables in-place merging.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_wb_buffer #(
  parameter int DATA_WIDTH    = 32,
  parameter int LINE_WORD_NUM = 4,
  parameter int DEPTH         = 4,
  parameter int OFFSET_WIDTH  = $clog2(LINE_WORD_NUM*DATA_WIDTH/8)
) (
  input  wire logic                                clk,
  input  wire logic                                resetn,
  input  wire logic                                push_valid,
  output logic                                     push_ready,
  input  wire logic [32-OFFSET_WIDTH-1:0]          push_addr,
  input  wire logic [LINE_WORD_NUM*DATA_WIDTH-1:0] push_line,
  input  wire logic [32-OFFSET_WIDTH-1:0]          lookup_addr,
  output logic                                     lookup_hit,
  output logic [LINE_WORD_NUM*DATA_WIDTH-1:0]      lookup_line,
  output logic                                     empty,
  cache_wb_buffer_if.master                        axi
);

  localparam int c_addr_w = 32 - OFFSET_WIDTH;
  localparam int c_line_w = LINE_WORD_NUM * DATA_WIDTH;
  localparam int c_ptr_w  = $clog2(DEPTH);
  localparam int c_cnt_w  = c_ptr_w + 1;
  localparam int c_beat_w = $clog2(LINE_WORD_NUM);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AW   = 2'd1,
    S_W    = 2'd2,
    S_B    = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_beat_w-1:0]   r_beat;
  logic [c_ptr_w-1:0]    r_head;
  logic [c_ptr_w-1:0]    r_tail;
  logic [c_cnt_w-1:0]    r_count;
  logic [DEPTH-1:0]      r_valid;
  logic [c_addr_w-1:0]   r_addr [DEPTH];
  logic [c_line_w-1:0]   r_line [DEPTH];

  logic                  w_push_fire;
  logic                  w_alloc;
  logic                  w_retire;
  logic                  w_last;
  logic                  w_merge_hit;
  logic [c_ptr_w-1:0]    w_merge_idx;
  logic [c_ptr_w-1:0]    w_lk_idx;

  assign push_ready  = (r_count != c_cnt_w'(DEPTH));
  assign empty       = (r_count == '0);
  assign w_push_fire = push_valid && push_ready;
  assign w_alloc     = w_push_fire && !w_merge_hit;
  assign w_retire    = (r_state == S_B) && axi.bvalid;
  assign w_last      = (r_beat == c_beat_w'(LINE_WORD_NUM - 1));

`ifdef WB_MERGE_EN
  // The head entry is excluded once its burst has started so in-flight data never changes.
  always_comb begin
    w_merge_hit = 1'b0;
    w_merge_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_addr[i] == push_addr) &&
          !((c_ptr_w'(i) == r_head) && (r_state != S_IDLE))) begin
        w_merge_hit = 1'b1;
        w_merge_idx = c_ptr_w'(i);
      end
    end
  end
`else
  assign w_merge_hit = 1'b0;
  assign w_merge_idx = '0;
`endif

  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_line = '0;
    w_lk_idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_lk_idx = r_head + c_ptr_w'(k);
      if (r_valid[w_lk_idx] && (r_addr[w_lk_idx] == lookup_addr)) begin
        lookup_hit  = 1'b1;
        lookup_line = r_line[w_lk_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      if (w_retire) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      case ({w_alloc, w_retire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset: the valid bits qualify every read.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_addr[r_tail] <= push_addr;
      r_line[r_tail] <= push_line;
    end else if (w_push_fire && w_merge_hit) begin
      r_line[w_merge_idx] <= push_line;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_W) && axi.wready) begin
        r_beat <= w_last ? '0 : r_beat + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) w_state_nxt = S_AW;
      end
      S_AW: begin
        axi.awvalid = 1'b1;
        if (axi.awready) w_state_nxt = S_W;
      end
      S_W: begin
        axi.wvalid = 1'b1;
        if (axi.wready && w_last) w_state_nxt = S_B;
      end
      S_B: begin
        axi.bready = 1'b1;
        if (axi.bvalid) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    axi.wdata = '0;
    for (int w = 0; w < LINE_WORD_NUM; w++) begin
      if (r_beat == c_beat_w'(w)) axi.wdata = r_line[r_head][w*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign axi.awaddr  = {r_addr[r_head], {OFFSET_WIDTH{1'b0}}};
  assign axi.awlen   = 8'(LINE_WORD_NUM - 1);
  assign axi.awsize  = 3'($clog2(DATA_WIDTH/8));
  assign axi.awburst = 2'b01;
  assign axi.wstrb   = '1;
  assign axi.wlast   = (r_state == S_W) && w_last;

endmodule

`default_nettype wire

// File: tb/tb_cache_wb_buffer.sv
// Scoreboard bench for cache_wb_buffer: directed pushes queue expected bursts,
// a negedge monitor pops and compares every AW/W handshake.
`default_nettype none

module tb_cache_wb_buffer;
  localparam int DW    = 32;
  localparam int LWN   = 4;
  localparam int DEPTH = 4;
  localparam int OW    = 4;
  localparam int AW    = 32 - OW;
  localparam int LW    = LWN * DW;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          push_valid;
  logic          push_ready;
  logic [AW-1:0] push_addr;
  logic [LW-1:0] push_line;
  logic [AW-1:0] lookup_addr;
  logic          lookup_hit;
  logic [LW-1:0] lookup_line;
  logic          empty;
  logic          b_en;
  int            pend = 0;
  logic          hw, hb;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_aw [$];
  logic [32:0] exp_w  [$];

  always #5 clk = ~clk;

  cache_wb_buffer_if #(.DATA_WIDTH(DW)) axi ();

  cache_wb_buffer #(
    .DATA_WIDTH(DW), .LINE_WORD_NUM(LWN), .DEPTH(DEPTH), .OFFSET_WIDTH(OW)
  ) dut (
    .clk(clk), .resetn(resetn),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_addr(push_addr), .push_line(push_line),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_line(lookup_line),
    .empty(empty), .axi(axi.master)
  );

  assign axi.bvalid = b_en && (pend > 0);

  task automatic check(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_line(logic [AW-1:0] a, logic [LW-1:0] l);
    exp_aw.push_back({a, 4'h0});
    for (int w = 0; w < LWN; w++) exp_w.push_back({(w == LWN - 1), l[w*DW +: DW]});
  endtask

  task automatic push(logic [AW-1:0] a, logic [LW-1:0] l);
    push_valid = 1'b1;
    push_addr  = a;
    push_line  = l;
    tick();
    push_valid = 1'b0;
  endtask

  task automatic wait_empty(string nm, int budget);
    int n = 0;
    while (!empty && n < budget) begin
      tick();
      n++;
    end
    check(nm, empty, 1'b1);
  endtask

  // Monitor: handshakes seen at negedge complete on the following posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (axi.awvalid && axi.awready) begin
          if (exp_aw.size() == 0) begin
            checks++; errors++;
            $display("FAIL aw_unexpected: got awaddr %0h expected no burst", axi.awaddr);
          end else begin
            check("awaddr", axi.awaddr, exp_aw.pop_front());
            check("awlen", axi.awlen, 8'd3);
            check("awsize", axi.awsize, 3'd2);
            check("awburst", axi.awburst, 2'b01);
          end
        end
        if (axi.wvalid && axi.wready) begin
          if (exp_w.size() == 0) begin
            checks++; errors++;
            $display("FAIL w_unexpected: got wdata %0h expected no beat", axi.wdata);
          end else begin
            check("wlast_wdata", {axi.wlast, axi.wdata}, exp_w.pop_front());
            check("wstrb", axi.wstrb, 4'hf);
          end
        end
      end
    end
  end

  // Memory-side responder: one B per completed burst, released when b_en is set.
  initial begin
    forever begin
      @(negedge clk);
      hw = resetn && axi.wvalid && axi.wready && axi.wlast;
      hb = resetn && axi.bvalid && axi.bready;
      @(posedge clk);
      #1;
      if (!resetn) pend = 0;
      else begin
        if (hw) pend++;
        if (hb) pend--;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a_a, a_b, a_c;
    logic [LW-1:0] l_x, l_y;
    int n;
    push_valid = 1'b0; push_addr = '0; push_line = '0; lookup_addr = '0;
    axi.awready = 1'b0; axi.wready = 1'b0; b_en = 1'b0;

    resetn = 1'b0;
    repeat (3) tick();
    check("rst_awvalid", axi.awvalid, 1'b0);
    check("rst_wvalid", axi.wvalid, 1'b0);
    check("rst_bready", axi.bready, 1'b0);
    check("rst_wlast", axi.wlast, 1'b0);
    check("rst_lookup_hit", lookup_hit, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_push_ready", push_ready, 1'b1);
    resetn = 1'b1;
    tick();

    // Single line, free-flowing slave
    axi.awready = 1'b1; axi.wready = 1'b1; b_en = 1'b1;
    expect_line(28'h0040000, {32'd4, 32'd3, 32'd2, 32'd1});
    push(28'h0040000, {32'd4, 32'd3, 32'd2, 32'd1});
    check("t1_not_empty", empty, 1'b0);
    wait_empty("t1_empty", 30);

    // Fill to full with AW stalled
    axi.awready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      expect_line(28'h0000100 + AW'(i), {4{32'h1000_0000 + 32'(i)}} + 128'(i));
      push(28'h0000100 + AW'(i), {4{32'h1000_0000 + 32'(i)}} + 128'(i));
    end
    check("t2_full_not_ready", push_ready, 1'b0);
    push(28'h00001FF, {4{32'hDEAD_BEEF}});
    check("t2_full_still", push_ready, 1'b0);
    axi.awready = 1'b1;
    n = 0;
    while (!push_ready && n < 40) begin tick(); n++; end
    check("t2_ready_after_b", push_ready, 1'b1);
    wait_empty("t2_empty", 100);

    // Lookup, including same-cycle push invisibility
    axi.awready = 1'b0;
    a_a = 28'h0ABCDE0;
    l_x = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    expect_line(a_a, l_x);
    push_valid = 1'b1; push_addr = a_a; push_line = l_x; lookup_addr = a_a;
    #1;
    check("t3_same_cycle_miss", lookup_hit, 1'b0);
    tick();
    push_valid = 1'b0;
    #1;
    check("t3_hit", lookup_hit, 1'b1);
    check("t3_line", lookup_line, l_x);
    lookup_addr = 28'h0ABCDE1;
    #1;
    check("t3_other_miss", lookup_hit, 1'b0);
    axi.awready = 1'b1;
    wait_empty("t3_empty", 30);
    lookup_addr = a_a;
    #1;
    check("t3_miss_after_retire", lookup_hit, 1'b0);

    // Duplicate address behind a draining head
    axi.awready = 1'b0;
    a_c = 28'h0000C00; a_a = 28'h0000A00; a_b = 28'h0000B00;
    l_x = {4{32'h1111_1111}};
    l_y = {4{32'h2222_2222}};
    expect_line(a_c, {4{32'hCCCC_CCCC}});
`ifdef WB_MERGE_EN
    expect_line(a_a, l_y);
    expect_line(a_b, {4{32'hBBBB_BBBB}});
`else
    expect_line(a_a, l_x);
    expect_line(a_b, {4{32'hBBBB_BBBB}});
    expect_line(a_a, l_y);
`endif
    push(a_c, {4{32'hCCCC_CCCC}});
    push(a_a, l_x);
    push(a_b, {4{32'hBBBB_BBBB}});
    push(a_a, l_y);
    lookup_addr = a_a;
    #1;
    check("t4_hit", lookup_hit, 1'b1);
    check("t4_youngest", lookup_line, l_y);
`ifdef WB_MERGE_EN
    check("t4_merge_ready", push_ready, 1'b1);
`else
    check("t4_full_ready", push_ready, 1'b0);
`endif
    axi.awready = 1'b1;
    wait_empty("t4_empty", 100);

    // Push offered while full in the retire cycle
    axi.awready = 1'b0; b_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      expect_line(28'h0000D00 + AW'(i), {4{32'hD000_0000 + 32'(i)}});
      push(28'h0000D00 + AW'(i), {4{32'hD000_0000 + 32'(i)}});
    end
    axi.awready = 1'b1;
    n = 0;
    while (!axi.bready && n < 20) begin tick(); n++; end
    check("t5_in_b", axi.bready, 1'b1);
    expect_line(28'h0000E00, {4{32'hEEEE_EEEE}});
    b_en = 1'b1;
    push_valid = 1'b1; push_addr = 28'h0000E00; push_line = {4{32'hEEEE_EEEE}};
    #1;
    check("t5_full_at_retire", push_ready, 1'b0);
    tick();
    check("t5_ready_after_retire", push_ready, 1'b1);
    tick();
    push_valid = 1'b0;
    check("t5_full_again", push_ready, 1'b0);
    wait_empty("t5_empty", 150);

    // Reset in the middle of the W phase
    expect_line(28'h0000F00, {32'hF3, 32'hF2, 32'hF1, 32'hF0});
    void'(exp_w.pop_back());
    void'(exp_w.pop_back());
    push(28'h0000F00, {32'hF3, 32'hF2, 32'hF1, 32'hF0});
    n = 0;
    while (!axi.wvalid && n < 10) begin tick(); n++; end
    check("t6_wvalid", axi.wvalid, 1'b1);
    tick();
    tick();
    resetn = 1'b0;
    tick();
    check("t6_wvalid_low", axi.wvalid, 1'b0);
    check("t6_awvalid_low", axi.awvalid, 1'b0);
    check("t6_empty", empty, 1'b1);
    check("t6_push_ready", push_ready, 1'b1);
    resetn = 1'b1;
    repeat (10) tick();
    check("t6_idle_after", axi.wvalid | axi.awvalid, 1'b0);

    check("sb_aw_drained", exp_aw.size(), 0);
    check("sb_w_drained", exp_w.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
